// File: rtl/stage_wb_pipe.sv
// MEM/WB pipeline register with RV32I load extraction, write-back source
// selection and a retired-instruction counter. Every output is a register.
module stage_wb_pipe #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      EX_MEM_valid,
    input  logic                      EX_MEM_reg_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic [1:0]                EX_MEM_wb_sel,
    input  logic [2:0]                EX_MEM_load_type,
    input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]      EX_MEM_pc_plus4,
    input  logic [REG_WIDTH-1:0]      DMEM_data_out,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      MEM_WB_valid,
    output logic                      MEM_WB_reg_write_en,
    output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
    output logic [REG_WIDTH-1:0]      MEM_WB_wb_data,
    output logic                      MEM_WB_misalign,
    output logic [CNT_WIDTH-1:0]      MEM_WB_instret
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_type_e;

    logic [1:0]           offset;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [REG_WIDTH-1:0] load_data;
    logic                 load_misaligned;
    logic [REG_WIDTH-1:0] wb_data_next;
    logic                 misalign_next;
    logic                 reg_write_next;
    logic                 retire;

    assign offset = EX_MEM_alu_out[1:0];

    // Little-endian lane selection and extension of the DMEM read word.
    always_comb begin
        byte_sel        = DMEM_data_out[7:0];
        half_sel        = offset[1] ? DMEM_data_out[31:16] : DMEM_data_out[15:0];
        load_data       = DMEM_data_out;
        load_misaligned = (offset != 2'b00);
        case (offset)
            2'd1:    byte_sel = DMEM_data_out[15:8];
            2'd2:    byte_sel = DMEM_data_out[23:16];
            2'd3:    byte_sel = DMEM_data_out[31:24];
            default: byte_sel = DMEM_data_out[7:0];
        endcase
        case (EX_MEM_load_type)
            LD_B: begin
                load_data       = {{(REG_WIDTH-8){byte_sel[7]}}, byte_sel};
                load_misaligned = 1'b0;
            end
            LD_BU: begin
                load_data       = {{(REG_WIDTH-8){1'b0}}, byte_sel};
                load_misaligned = 1'b0;
            end
            LD_H: begin
                load_data       = {{(REG_WIDTH-16){half_sel[15]}}, half_sel};
                load_misaligned = offset[0];
            end
            LD_HU: begin
                load_data       = {{(REG_WIDTH-16){1'b0}}, half_sel};
                load_misaligned = offset[0];
            end
            default: begin
                load_data       = DMEM_data_out;
                load_misaligned = (offset != 2'b00);
            end
        endcase
    end

    // Write-back source mux and the qualified control bits for the next entry.
    always_comb begin
        case (EX_MEM_wb_sel)
            WB_LOAD: wb_data_next = load_data;
            WB_PC4:  wb_data_next = EX_MEM_pc_plus4;
            default: wb_data_next = EX_MEM_alu_out;
        endcase
        misalign_next  = EX_MEM_valid && (EX_MEM_wb_sel == WB_LOAD) && load_misaligned;
        reg_write_next = EX_MEM_valid && EX_MEM_reg_write_en &&
                         (EX_MEM_rd != '0) && !misalign_next;
        retire         = EX_MEM_valid && !misalign_next;
    end

    // Pipeline register: flush bubbles the control bits, stall holds everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MEM_WB_valid        <= 1'b0;
            MEM_WB_reg_write_en <= 1'b0;
            MEM_WB_rd           <= '0;
            MEM_WB_wb_data      <= '0;
            MEM_WB_misalign     <= 1'b0;
            MEM_WB_instret      <= '0;
        end else if (flush) begin
            MEM_WB_valid        <= 1'b0;
            MEM_WB_reg_write_en <= 1'b0;
            MEM_WB_misalign     <= 1'b0;
        end else if (!stall) begin
            MEM_WB_valid        <= EX_MEM_valid;
            MEM_WB_reg_write_en <= reg_write_next;
            MEM_WB_rd           <= EX_MEM_rd;
            MEM_WB_wb_data      <= wb_data_next;
            MEM_WB_misalign     <= misalign_next;
            MEM_WB_instret      <= MEM_WB_instret + CNT_WIDTH'(retire);
        end
    end

endmodule

// File: tb/tb_stage_wb_pipe.sv
// Scoreboard bench for stage_wb_pipe: the driver pushes hand-computed
// expected outputs per vector, the monitor pops and compares after each edge.
module tb_stage_wb_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        EX_MEM_valid;
    logic        EX_MEM_reg_write_en;
    logic [4:0]  EX_MEM_rd;
    logic [1:0]  EX_MEM_wb_sel;
    logic [2:0]  EX_MEM_load_type;
    logic [31:0] EX_MEM_alu_out;
    logic [31:0] EX_MEM_pc_plus4;
    logic [31:0] DMEM_data_out;
    logic        stall;
    logic        flush;
    logic        MEM_WB_valid;
    logic        MEM_WB_reg_write_en;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_wb_data;
    logic        MEM_WB_misalign;
    logic [3:0]  MEM_WB_instret;

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic [3:0]  cnt;
        int          id;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         vec_id   = 0;
    logic [3:0] exp_cnt  = '0;

    stage_wb_pipe #(
        .REG_WIDTH      (32),
        .REG_ADDR_WIDTH (5),
        .CNT_WIDTH      (4)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .EX_MEM_valid        (EX_MEM_valid),
        .EX_MEM_reg_write_en (EX_MEM_reg_write_en),
        .EX_MEM_rd           (EX_MEM_rd),
        .EX_MEM_wb_sel       (EX_MEM_wb_sel),
        .EX_MEM_load_type    (EX_MEM_load_type),
        .EX_MEM_alu_out      (EX_MEM_alu_out),
        .EX_MEM_pc_plus4     (EX_MEM_pc_plus4),
        .DMEM_data_out       (DMEM_data_out),
        .stall               (stall),
        .flush               (flush),
        .MEM_WB_valid        (MEM_WB_valid),
        .MEM_WB_reg_write_en (MEM_WB_reg_write_en),
        .MEM_WB_rd           (MEM_WB_rd),
        .MEM_WB_wb_data      (MEM_WB_wb_data),
        .MEM_WB_misalign     (MEM_WB_misalign),
        .MEM_WB_instret      (MEM_WB_instret)
    );

    always #5 clk = ~clk;

    // Drive one vector on the falling edge and queue what the next rising edge must produce.
    task automatic apply(
        input logic v, input logic we, input logic [4:0] rd, input logic [1:0] sel,
        input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] pc,
        input logic [31:0] dm, input logic st, input logic fl,
        input logic ev, input logic ewe, input logic [4:0] erd,
        input logic [31:0] edata, input logic emis, input logic inc);
        exp_t e;
        @(negedge clk);
        EX_MEM_valid        = v;
        EX_MEM_reg_write_en = we;
        EX_MEM_rd           = rd;
        EX_MEM_wb_sel       = sel;
        EX_MEM_load_type    = lt;
        EX_MEM_alu_out      = alu;
        EX_MEM_pc_plus4     = pc;
        DMEM_data_out       = dm;
        stall               = st;
        flush               = fl;
        if (inc) exp_cnt = exp_cnt + 4'd1;
        e.v = ev; e.we = ewe; e.rd = erd; e.data = edata; e.mis = emis;
        e.cnt = exp_cnt; e.id = vec_id;
        sb.push_back(e);
        vec_id++;
    endtask

    // Bounded wait for the monitor to consume every queued expectation.
    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare registered outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (MEM_WB_valid !== e.v || MEM_WB_reg_write_en !== e.we ||
                    MEM_WB_rd !== e.rd || MEM_WB_wb_data !== e.data ||
                    MEM_WB_misalign !== e.mis || MEM_WB_instret !== e.cnt) begin
                    n_fail++;
                    $display("FAIL vec%0d: got v=%b we=%b rd=%0d data=%h mis=%b cnt=%0d, required v=%b we=%b rd=%0d data=%h mis=%b cnt=%0d",
                             e.id, MEM_WB_valid, MEM_WB_reg_write_en, MEM_WB_rd,
                             MEM_WB_wb_data, MEM_WB_misalign, MEM_WB_instret,
                             e.v, e.we, e.rd, e.data, e.mis, e.cnt);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_checks++;
        if ({MEM_WB_valid, MEM_WB_reg_write_en, MEM_WB_rd, MEM_WB_wb_data,
             MEM_WB_misalign, MEM_WB_instret} !== '0) begin
            n_fail++;
            $display("FAIL %s: got v=%b we=%b rd=%0d data=%h mis=%b cnt=%0d, required all 0",
                     name, MEM_WB_valid, MEM_WB_reg_write_en, MEM_WB_rd,
                     MEM_WB_wb_data, MEM_WB_misalign, MEM_WB_instret);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        reset_n = 1'b1;
        EX_MEM_valid = 1'b0; EX_MEM_reg_write_en = 1'b0; EX_MEM_rd = '0;
        EX_MEM_wb_sel = '0; EX_MEM_load_type = '0; EX_MEM_alu_out = '0;
        EX_MEM_pc_plus4 = '0; DMEM_data_out = '0; stall = 1'b0; flush = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_zero("reset_state");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        //     v  we rd     sel    lt      alu           pc            dm            st fl   ev ewe erd    edata         mis inc
        apply(1, 1, 5'd5,  2'b01, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0,  1, 1, 5'd5,  32'hFFFF_FF80, 0, 1); // LB
        apply(1, 1, 5'd5,  2'b01, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0,  1, 1, 5'd5,  32'h0000_0080, 0, 1); // LBU
        apply(1, 1, 5'd5,  2'b01, 3'b101, 32'h0000_1002, 32'h0,        32'h80FF_1234, 0, 0,  1, 1, 5'd5,  32'h0000_80FF, 0, 1); // LHU
        apply(1, 1, 5'd5,  2'b01, 3'b001, 32'h0000_1001, 32'h0,        32'h80FF_1234, 0, 0,  1, 0, 5'd5,  32'h0000_1234, 1, 0); // LH misaligned
        apply(1, 1, 5'd5,  2'b01, 3'b001, 32'h0000_1002, 32'h0,        32'h80FF_1234, 0, 0,  1, 1, 5'd5,  32'hFFFF_80FF, 0, 1); // LH upper
        apply(1, 1, 5'd7,  2'b01, 3'b010, 32'h0000_1000, 32'h0,        32'hCAFE_F00D, 0, 0,  1, 1, 5'd7,  32'hCAFE_F00D, 0, 1); // LW
        apply(1, 1, 5'd7,  2'b01, 3'b010, 32'h0000_1002, 32'h0,        32'hCAFE_F00D, 0, 0,  1, 0, 5'd7,  32'hCAFE_F00D, 1, 0); // LW misaligned
        apply(1, 1, 5'd7,  2'b01, 3'b011, 32'h0000_1000, 32'h0,        32'h0BAD_F00D, 0, 0,  1, 1, 5'd7,  32'h0BAD_F00D, 0, 1); // odd code as LW
        apply(1, 1, 5'd7,  2'b01, 3'b011, 32'h0000_1001, 32'h0,        32'h0BAD_F00D, 0, 0,  1, 0, 5'd7,  32'h0BAD_F00D, 1, 0); // odd code misaligned
        apply(1, 1, 5'd5,  2'b01, 3'b000, 32'h0000_1001, 32'h0,        32'h80FF_1234, 0, 0,  1, 1, 5'd5,  32'h0000_0012, 0, 1); // LB offset 1
        apply(1, 1, 5'd1,  2'b10, 3'b000, 32'h0000_1003, 32'h0000_0044, 32'h0,        0, 0,  1, 1, 5'd1,  32'h0000_0044, 0, 1); // PC+4
        apply(1, 1, 5'd0,  2'b10, 3'b000, 32'h0000_1003, 32'h0000_0044, 32'h0,        0, 0,  1, 0, 5'd0,  32'h0000_0044, 0, 1); // rd=0
        apply(1, 1, 5'd3,  2'b00, 3'b001, 32'hDEAD_BEEF, 32'h0,        32'h0,         0, 0,  1, 1, 5'd3,  32'hDEAD_BEEF, 0, 1); // ALU
        for (int i = 0; i < 3; i++)
            apply(1, 1, 5'd9, 2'b11, 3'b000, 32'h1234_5678, 32'h0,     32'h0,         1, 0,  1, 1, 5'd3,  32'hDEAD_BEEF, 0, 0); // stall
        apply(1, 1, 5'd9,  2'b11, 3'b000, 32'h1234_5678, 32'h0,        32'h0,         0, 0,  1, 1, 5'd9,  32'h1234_5678, 0, 1); // release, sel=11
        apply(0, 1, 5'd4,  2'b00, 3'b000, 32'h0000_0055, 32'h0,        32'h0,         0, 0,  0, 0, 5'd4,  32'h0000_0055, 0, 0); // invalid
        apply(0, 1, 5'd4,  2'b01, 3'b010, 32'h0000_1001, 32'h0,        32'hCAFE_F00D, 0, 0,  0, 0, 5'd4,  32'hCAFE_F00D, 0, 0); // invalid misaligned
        apply(1, 1, 5'd2,  2'b00, 3'b000, 32'h0000_0011, 32'h0,        32'h0,         0, 0,  1, 1, 5'd2,  32'h0000_0011, 0, 1);
        apply(1, 1, 5'd6,  2'b00, 3'b000, 32'h0000_AAAA, 32'h0,        32'h0,         1, 1,  0, 0, 5'd2,  32'h0000_0011, 0, 0); // stall+flush
        apply(1, 1, 5'd6,  2'b00, 3'b000, 32'h0000_AAAA, 32'h0,        32'h0,         0, 0,  1, 1, 5'd6,  32'h0000_AAAA, 0, 1);
        apply(1, 1, 5'd8,  2'b01, 3'b010, 32'h0000_1003, 32'h0,        32'hCAFE_F00D, 0, 0,  1, 0, 5'd8,  32'hCAFE_F00D, 1, 0); // misaligned
        apply(1, 1, 5'd9,  2'b00, 3'b000, 32'h0000_0077, 32'h0,        32'h0,         0, 1,  0, 0, 5'd8,  32'hCAFE_F00D, 0, 0); // flush clears mis
        // Counter wrap: 17 back-to-back retirements pass through 15, 0, 1.
        for (int i = 0; i < 17; i++)
            apply(1, 1, 5'd10, 2'b00, 3'b000, 32'h100 + 32'(i), 32'h0, 32'h0,         0, 0,  1, 1, 5'd10, 32'h100 + 32'(i), 0, 1);
        drain();

        // Asynchronous reset while stalled.
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero("reset_mid_stall");
        exp_cnt = '0;
        @(negedge clk);
        reset_n = 1'b1;
        apply(1, 1, 5'd11, 2'b00, 3'b000, 32'h0000_0099, 32'h0,        32'h0,         0, 0,  1, 1, 5'd11, 32'h0000_0099, 0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
